register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter REG_CNT, default 32, meaning number of GPRs (power of two, >= 2); AW = $clog2(REG_CNT).
REQ-002 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a1, a2  input  AW  source register addresses.
REQ-006 SHALL have ports rd1, rd2  output  XLEN  source register data.
REQ-007 SHALL have ports busy1, busy2  output  1  scoreboard busy flag of a1 / a2.
REQ-008 SHALL have ports a3, di3, we3  input  AW/XLEN/1  write port 3 (pipeline writeback).
REQ-009 SHALL have ports a4, di4, we4  input  AW/XLEN/1  write port 4 (long-latency unit writeback; also clears busy).
REQ-010 SHALL have ports iss_valid, iss_rd  input  1/AW  issue request reserving destination iss_rd.
REQ-011 SHALL have port iss_ready  output  1  issue accepted this cycle when high with iss_valid.
REQ-012 SHALL have port busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-013 SHALL read rd1/rd2 combinationally; address 0 SHALL always read 0 and busy 0.
REQ-014 SHALL write di3 to rf[a3] when we3 && a3 != 0, and di4 to rf[a4] when we4 && a4 != 0, both at the rising edge.
REQ-015 SHALL give port 4 priority when we3 && we4 && a3 == a4: rf gets di4.
REQ-016 SHALL drive iss_ready = !busy[iss_rd], combinationally; iss_rd == 0 SHALL always be ready and SHALL NOT set busy.
REQ-017 SHALL set busy[iss_rd] at the edge when iss_valid && iss_ready && iss_rd != 0.
REQ-018 SHALL clear busy[a4] at the edge when we4 && a4 != 0; we3 SHALL NOT affect busy.
REQ-019 SHALL leave busy = 1 when set (REQ-017) and clear (REQ-018) hit the same register in the same cycle.
REQ-020 SHALL NOT allow a port-4 write to a non-busy register to change the scoreboard; the data write still occurs.
REQ-021 SHALL keep busy_cnt equal to the population count of busy[], registered and updated with the busy bits (+1, -1, or 0 net per cycle).
REQ-022 SHALL give simultaneous set of one register and clear of another a net busy_cnt change of 0.

Reset
REQ-023 SHALL, while rst_n is low and independent of clk, clear all rf entries, all busy bits and busy_cnt to 0.
REQ-024 SHALL hold iss_ready = 1, rd1 = rd2 = 0 and busy1 = busy2 = 0 during reset.
REQ-025 SHALL ignore writes and issues in the cycle rst_n deasserts only if the edge coincides with reset low; the first edge with rst_n high SHALL act normally.

Configuration
REQ-026 SHALL, with macro RF_BYPASS_EN defined, forward same-cycle writes to reads: rdN = di4 if we4 && a4 == aN, else di3 if we3 && a3 == aN, else rf[aN] (aN != 0); busyN SHALL read 0 when port 4 clears aN that cycle, unless it is also set that cycle.
REQ-027 SHALL, without RF_BYPASS_EN, return the pre-edge rf/busy contents on rd1/rd2/busy1/busy2 (write visible the following cycle).

Verification
REQ-028 SHALL cover: reset with rf loaded -> rst_n low mid-cycle -> rd1 = 0, busy_cnt = 0 immediately, no clock needed.
REQ-029 SHALL cover: we3, a3 = 0, di3 = 0xDEADBEEF; read a1 = 0 -> rd1 = 0; same write to a3 = 5 -> next cycle rd1(a1 = 5) = 0xDEADBEEF.
REQ-030 SHALL cover: we3/we4 both to x7 with 0x11/0x22 -> rf[7] = 0x22.
REQ-031 SHALL cover: issue x9 -> busy_cnt = 1, iss_ready(iss_rd = 9) = 0; we4 a4 = 9 di4 = 0x55 -> busy cleared, busy_cnt = 0, rd = 0x55.
REQ-032 SHALL cover: issue x9 while we4 clears x9 same cycle -> busy[9] stays 1; issue x3 while clearing x9 -> busy_cnt unchanged.
REQ-033 SHALL cover: with RF_BYPASS_EN, we4 a4 = 4 di4 = 0xA5, a1 = 4 same cycle -> rd1 = 0xA5; without the macro -> rd1 = old value.

Source files
------------

// File: rtl/register_file_sb.sv
// Register file with two read ports, two write ports and a per-register busy scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle writes and busy clears to the read ports.
module register_file_sb #(
   parameter int unsigned REG_CNT = 32,
   parameter int unsigned XLEN    = 32,
   localparam int unsigned AW     = $clog2(REG_CNT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] di3,
   input  logic            we3,
   input  logic [AW-1:0]   a4,
   input  logic [XLEN-1:0] di4,
   input  logic            we4,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_ready,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0]    rf_q [REG_CNT];
   logic [XLEN-1:0]    rf_d [REG_CNT];
   logic [REG_CNT-1:0] busy_q, busy_d;
   logic [AW:0]        busy_cnt_q, busy_cnt_d;
   logic               set_en, clr_en;
   logic [REG_CNT-1:0] set_vec, clr_vec;

   always_comb begin
      iss_ready = (iss_rd == '0) || !busy_q[iss_rd];
      set_en    = iss_valid && iss_ready && (iss_rd != '0);
      // A clear only counts when the target is actually busy, so a set and clear of the
      // same register can never both change the count.
      clr_en    = we4 && (a4 != '0) && busy_q[a4];
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en) set_vec[iss_rd] = 1'b1;
      if (clr_en) clr_vec[a4] = 1'b1;
      busy_d     = (busy_q & ~clr_vec) | set_vec;
      busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, set_en} - {{AW{1'b0}}, clr_en};
   end

   always_comb begin
      rf_d = rf_q;
      if (we3 && (a3 != '0)) rf_d[a3] = di3;
      if (we4 && (a4 != '0)) rf_d[a4] = di4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(REG_CNT); i++) rf_q[i] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         rf_q       <= rf_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

`ifdef RF_BYPASS_EN
   logic clr_hit1, clr_hit2, set_hit1, set_hit2;

   always_comb begin
      clr_hit1 = we4 && (a4 == a1);
      clr_hit2 = we4 && (a4 == a2);
      set_hit1 = set_en && (iss_rd == a1);
      set_hit2 = set_en && (iss_rd == a2);

      rd1 = '0;
      if (rst_n && (a1 != '0)) begin
         if (we4 && (a4 == a1))      rd1 = di4;
         else if (we3 && (a3 == a1)) rd1 = di3;
         else                        rd1 = rf_q[a1];
      end
      rd2 = '0;
      if (rst_n && (a2 != '0)) begin
         if (we4 && (a4 == a2))      rd2 = di4;
         else if (we3 && (a3 == a2)) rd2 = di3;
         else                        rd2 = rf_q[a2];
      end

      busy1 = rst_n && (a1 != '0) && (clr_hit1 ? set_hit1 : busy_q[a1]);
      busy2 = rst_n && (a2 != '0) && (clr_hit2 ? set_hit2 : busy_q[a2]);
   end
`else
   always_comb begin
      rd1   = (a1 == '0) ? '0 : rf_q[a1];
      rd2   = (a2 == '0) ? '0 : rf_q[a2];
      busy1 = (a1 != '0) && busy_q[a1];
      busy2 = (a2 != '0) && busy_q[a2];
   end
`endif

endmodule

// File: tb/tb_register_file_sb.sv
// Directed plus randomized bench for register_file_sb against an array-based reference model.
module tb_register_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  a1, a2, a3, a4, iss_rd;
   logic [31:0] rd1, rd2, di3, di4;
   logic        busy1, busy2, we3, we4, iss_valid, iss_ready;
   logic [5:0]  busy_cnt;

   int vecs = 0;
   int errs = 0;

   logic [31:0] m_rf [32];
   bit          m_busy [32];

   register_file_sb dut (
      .clk(clk), .rst_n(rst_n),
      .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
      .a3(a3), .di3(di3), .we3(we3),
      .a4(a4), .di4(di4), .we4(we4),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic int popcnt();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (we4 && a4 == a) return di4;
      if (we3 && a3 == a) return di3;
`endif
      return m_rf[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (we4 && a4 == a) return iss_valid && iss_rd == a && !m_busy[a];
`endif
      return m_busy[a];
   endfunction

   task automatic model_edge();
      bit ready;
      ready = (iss_rd == 0) || !m_busy[iss_rd];
      if (we3 && a3 != 0) m_rf[a3] = di3;
      if (we4 && a4 != 0) m_rf[a4] = di4;
      if (we4 && a4 != 0) m_busy[a4] = 1'b0;
      if (iss_valid && ready && iss_rd != 0) m_busy[iss_rd] = 1'b1;
   endtask

   task automatic check_comb();
      check("rd1", rd1, exp_rd(a1));
      check("rd2", rd2, exp_rd(a2));
      check("busy1", {31'b0, busy1}, {31'b0, exp_busy(a1)});
      check("busy2", {31'b0, busy2}, {31'b0, exp_busy(a2)});
      check("iss_ready", {31'b0, iss_ready},
            {31'b0, (iss_rd == 0) || !m_busy[iss_rd]});
   endtask

   // Inputs are applied 1 time unit after a rising edge; this checks then clocks once.
   task automatic step();
      #1;
      check_comb();
      @(posedge clk);
      model_edge();
      #1;
      check("busy_cnt", {26'b0, busy_cnt}, popcnt());
   endtask

   task automatic drive(input logic w3, input logic [4:0] ad3, input logic [31:0] d3,
                        input logic w4, input logic [4:0] ad4, input logic [31:0] d4,
                        input logic iv, input logic [4:0] ir,
                        input logic [4:0] r1, input logic [4:0] r2);
      we3 = w3; a3 = ad3; di3 = d3;
      we4 = w4; a4 = ad4; di4 = d4;
      iss_valid = iv; iss_rd = ir;
      a1 = r1; a2 = r2;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] ir);
      drive(0, 0, 0, 0, 0, 0, 0, ir, r1, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      idle(5, 9);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_comb();
      check("rst_cnt", {26'b0, busy_cnt}, 32'd0);
      rst_n = 1'b1;

      // Writes to x0 are discarded; a write to x5 shows up the next cycle.
      drive(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      step();
      idle(5, 0);
      #1 check("x5_read", rd1, 32'hDEADBEEF);
      step();

      // Same-address collision: port 4 wins.
      drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0);
      step();
      idle(7, 0);
      #1 check("x7_prio", rd1, 32'h22);
      step();

      // Issue x9, then long-latency writeback clears it.
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      step();
      idle(9, 9);
      #1 check("x9_notready", {31'b0, iss_ready}, 32'd0);
      check("cnt_one", {26'b0, busy_cnt}, 32'd1);
      step();
      drive(0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 0);
      step();
      idle(9, 0);
      #1 check("x9_data", rd1, 32'h55);
      check("cnt_zero", {26'b0, busy_cnt}, 32'd0);
      step();

      // Set and clear of x9 together keeps it busy; set x3 while clearing x9 nets zero.
      drive(0, 0, 0, 1, 9, 32'h66, 1, 9, 9, 0);
      step();
      idle(9, 0);
      #1 check("x9_stays", {31'b0, busy1}, 32'd1);
      step();
      drive(0, 0, 0, 1, 9, 32'h77, 1, 3, 9, 3);
      step();
      check("cnt_net0", {26'b0, busy_cnt}, 32'd1);

      // Same-cycle write/read of x4.
      drive(0, 0, 0, 1, 4, 32'hA5, 0, 0, 4, 0);
      #1;
`ifdef RF_BYPASS_EN
      check("x4_fwd", rd1, 32'hA5);
`else
      check("x4_old", rd1, 32'h0);
`endif
      step();

      // Asynchronous reset mid-cycle with state loaded.
      idle(5, 3);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check("arst_rd1", rd1, 32'h0);
      check("arst_cnt", {26'b0, busy_cnt}, 32'd0);
      check("arst_ready", {31'b0, iss_ready}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int n = 0; n < 400; n++) begin
         logic [4:0] r1, r2, w3a, w4a, ir;
         r1  = 5'($urandom_range(0, 31));
         r2  = 5'($urandom_range(0, 7));
         w3a = 5'($urandom_range(0, 31));
         w4a = 5'($urandom_range(0, 7));
         ir  = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            r1 = w4a;
            w4a = ir;
         end
         drive(1'($urandom), w3a, $urandom, 1'($urandom_range(0, 2) == 0), w4a, $urandom,
               1'($urandom), ir, r1, r2);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
